// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and bit-order constants for the serializer
package piso_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;
    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;
endpackage

// File: rtl/piso_serializer_bit_counter.sv
// bit_counter: up-counter over one word with sync clear and terminal-count flag
module bit_counter #(
    parameter  int WORD_LENGTH = 4,
    localparam int CNT_W       = $clog2(WORD_LENGTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             tc
);
    logic [CNT_W-1:0] count_q, count_d;

    assign tc    = count_q == CNT_W'(WORD_LENGTH - 1);
    assign count = count_q;

    // wrap explicitly so non-power-of-two widths also return to zero
    always_comb count_d = clr ? '0 : inc ? (tc ? '0 : count_q + 1'b1) : count_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) count_q <= '0;
        else       count_q <= count_d;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out shifter with per-word bit order,
// done pulse, bit counting, chaining input and synchronous abort
module piso_serializer
    import piso_pkg::*;
#(
    parameter  int WORD_LENGTH = 4,
    localparam int CNT_W       = $clog2(WORD_LENGTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load,
    input  logic [WORD_LENGTH-1:0] data_in,
    input  logic                   msb_first,
    input  logic                   shift,
    input  logic                   serial_in,
    output logic                   data_out,
    output logic [WORD_LENGTH-1:0] data_q,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       bit_count
);
    state_e                 state_q, state_d;
    logic [WORD_LENGTH-1:0] sreg_q, sreg_d;
    logic                   mode_q, mode_d;
    logic                   tc, accept, adv;

    assign accept = ~clear & load & (state_q != ST_SHIFT);
    assign adv    = ~clear & shift & (state_q == ST_SHIFT);

    bit_counter #(.WORD_LENGTH(WORD_LENGTH)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clear | accept),
        .inc  (adv),
        .count(bit_count),
        .tc   (tc)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        mode_d  = mode_q;
        if (clear) begin
            state_d = ST_IDLE;
            sreg_d  = '0;
        end else if (accept) begin
            state_d = ST_SHIFT;
            sreg_d  = data_in;
            mode_d  = msb_first;
        end else if (adv) begin
            sreg_d  = (mode_q == MSB_FIRST) ? {sreg_q[WORD_LENGTH-2:0], serial_in}
                                            : {serial_in, sreg_q[WORD_LENGTH-1:1]};
            state_d = tc ? ST_DONE : ST_SHIFT;
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            mode_q  <= LSB_FIRST;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            mode_q  <= mode_d;
        end

    assign busy     = state_q == ST_SHIFT;
    assign done     = state_q == ST_DONE;
    assign data_q   = sreg_q;
    assign data_out = busy & ((mode_q == MSB_FIRST) ? sreg_q[WORD_LENGTH-1] : sreg_q[0]);
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed scoreboard bench for 4-bit and 8-bit serializers
module tb_piso_serializer;
    logic       clk = 1'b0;
    logic       reset;
    logic       a_clear, a_load, a_msb, a_shift, a_sin, a_dout, a_busy, a_done;
    logic [3:0] a_din, a_dq;
    logic [1:0] a_cnt;
    logic       b_clear, b_load, b_msb, b_shift, b_sin, b_dout, b_busy, b_done;
    logic [7:0] b_din, b_dq;
    logic [2:0] b_cnt;
    int         checks = 0;
    int         errors = 0;
    logic       exp_q[$];
    logic       pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    piso_serializer #(.WORD_LENGTH(4)) u4 (
        .clk(clk), .reset(reset), .clear(a_clear), .load(a_load), .data_in(a_din),
        .msb_first(a_msb), .shift(a_shift), .serial_in(a_sin), .data_out(a_dout),
        .data_q(a_dq), .busy(a_busy), .done(a_done), .bit_count(a_cnt)
    );

    piso_serializer #(.WORD_LENGTH(8)) u8 (
        .clk(clk), .reset(reset), .clear(b_clear), .load(b_load), .data_in(b_din),
        .msb_first(b_msb), .shift(b_shift), .serial_in(b_sin), .data_out(b_dout),
        .data_q(b_dq), .busy(b_busy), .done(b_done), .bit_count(b_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {a_clear, a_load, a_msb, a_shift, a_sin, a_din} = '0;
        {b_clear, b_load, b_msb, b_shift, b_sin, b_din} = '0;
        tick();
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_dq", a_dq, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", a_busy, 0);
        chk("idle_done", a_done, 0);
        // LSB-first 1011
        a_load = 1'b1; a_din = 4'b1011; a_msb = 1'b0;
        exp_q = '{1'b1, 1'b1, 1'b0, 1'b1};
        tick();
        a_load = 1'b0; a_shift = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("lsb_bit", a_dout, exp_q.pop_front());
            chk("lsb_cnt", a_cnt, i);
            chk("lsb_busy", a_busy, 1);
            chk("lsb_nodone", a_done, 0);
            tick();
        end
        chk("lsb_done", a_done, 1);
        chk("lsb_done_busy", a_busy, 0);
        chk("lsb_done_dout", a_dout, 0);
        a_shift = 1'b0;
        tick();
        chk("lsb_pulse", a_done, 0);
        chk("lsb_idle_busy", a_busy, 0);
        // MSB-first 1011 with serial_in fill of 1
        a_load = 1'b1; a_din = 4'b1011; a_msb = 1'b1; a_sin = 1'b1;
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        tick();
        a_load = 1'b0; a_shift = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("msb_bit", a_dout, exp_q.pop_front());
            chk("msb_cnt", a_cnt, i);
            tick();
        end
        chk("msb_done", a_done, 1);
        chk("msb_chain_dq", a_dq, 4'b1111);
        a_shift = 1'b0; a_sin = 1'b0;
        tick();
        // stalls plus a load while busy that must be ignored
        a_load = 1'b1; a_din = 4'b1011; a_msb = 1'b0;
        exp_q = '{1'b1, 1'b1, 1'b0, 1'b1};
        tick();
        a_load = 1'b0;
        for (int j = 0; j < 6; j++) begin
            chk("stall_bit", a_dout, exp_q[0]);
            chk("stall_busy", a_busy, 1);
            chk("stall_nodone", a_done, 0);
            a_shift = pat[j];
            a_load  = (j == 1);
            a_din   = (j == 1) ? 4'b0000 : 4'b1011;
            tick();
            if (pat[j]) void'(exp_q.pop_front());
        end
        chk("stall_done", a_done, 1);
        // back-to-back load in the DONE cycle
        a_load = 1'b1; a_din = 4'b0110; a_msb = 1'b0; a_shift = 1'b1;
        exp_q = '{1'b0, 1'b1, 1'b1, 1'b0};
        tick();
        a_load = 1'b0;
        chk("b2b_busy", a_busy, 1);
        chk("b2b_cnt", a_cnt, 0);
        for (int i = 0; i < 2; i++) begin
            chk("b2b_bit", a_dout, exp_q.pop_front());
            tick();
        end
        chk("abort_cnt_pre", a_cnt, 2);
        a_clear = 1'b1; a_load = 1'b1; a_din = 4'b1111;
        tick();
        a_clear = 1'b0; a_load = 1'b0; a_shift = 1'b0;
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        chk("abort_cnt", a_cnt, 0);
        chk("abort_dq", a_dq, 0);
        chk("abort_dout", a_dout, 0);
        tick();
        chk("abort_nodone", a_done, 0);
        chk("abort_idle", a_busy, 0);
        exp_q.delete();
        // 8-bit LSB-first A5 with counter wrap
        b_load = 1'b1; b_din = 8'hA5; b_msb = 1'b0;
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tick();
        b_load = 1'b0; b_shift = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("w8_bit", b_dout, exp_q.pop_front());
            chk("w8_cnt", b_cnt, i);
            chk("w8_nodone", b_done, 0);
            tick();
        end
        chk("w8_done", b_done, 1);
        chk("w8_wrap", b_cnt, 0);
        b_shift = 1'b0;
        tick();
        // asynchronous reset mid-word with random inputs
        a_load = 1'b1; a_din = 4'b1111; a_msb = 1'b0;
        tick();
        a_load = 1'b0; a_shift = 1'b1;
        tick();
        tick();
        chk("pre_rst_busy", a_busy, 1);
        {a_clear, a_load, a_msb, a_shift, a_sin} = 5'($urandom);
        a_din = 4'($urandom);
        {b_load, b_msb, b_shift, b_sin} = 4'($urandom);
        b_din = 8'($urandom);
        reset = 1'b1;
        #1;
        chk("arst_dout", a_dout, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_done", a_done, 0);
        chk("arst_cnt", a_cnt, 0);
        chk("arst_dq", a_dq, 0);
        chk("arst_b_dq", b_dq, 0);
        tick();
        {a_clear, a_load, a_shift, b_load, b_shift} = '0;
        reset = 1'b0;
        tick();
        chk("post_rst_busy", a_busy, 0);
        chk("post_rst_done", a_done, 0);
        tick();
        chk("post_rst_nodone", a_done, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out serializer that feeds operand bits to the sequential multiplier datapath. It captures a WORD_LENGTH-bit word on `load` and emits one bit per `shift` strobe. Bit order is LSB-first or MSB-first, selected per word. A `done` pulse marks the end of each word, and `serial_in` allows chaining several serializers. It replaces the fixed 4-bit right-shift register and adds bit order, completion handshake, bit counting and synchronous abort.

Parameters:
WORD_LENGTH, 4, serialized word width; legal range is 2 or more.
CNT_W, $clog2(WORD_LENGTH), bit_count width (derived localparam, not overridable).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
clear  input  1  synchronous abort to IDLE.
load  input  1  capture data_in (accepted only in IDLE or DONE).
data_in  input  WORD_LENGTH  parallel word.
msb_first  input  1  bit order, sampled with load; 0 = LSB first, 1 = MSB first.
shift  input  1  advance one bit (honoured only in SHIFT).
serial_in  input  1  fill bit inserted at the vacated end on each shift.
data_out  output  1  current serial bit.
data_q  output  WORD_LENGTH  shift register contents.
busy  output  1  high in SHIFT.
done  output  1  one-cycle pulse after the last bit is consumed.
bit_count  output  CNT_W  index of the bit currently presented.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-high; while reset=1, state is forced regardless of clk.
  - Reset values: state=IDLE, shift register=0, mode_r=0, data_out=0, data_q=0, busy=0, done=0, bit_count=0.
- Input priority each cycle: reset > clear > load > shift.
- States: IDLE, SHIFT, DONE. All outputs are derived from registers only; there is no combinational input-to-output path.
- IDLE:
  - load=1: shift register <= data_in, mode_r <= msb_first, bit_count <= 0, next state SHIFT.
  - shift is ignored in IDLE, including when it coincides with load.
- SHIFT:
  - busy=1.
  - data_out = sreg[0] when mode_r=0; sreg[WORD_LENGTH-1] when mode_r=1.
  - The first bit is valid in the cycle after load (1-cycle latency).
  - shift=1, mode_r=0: sreg <= {serial_in, sreg[W-1:1]}.
  - shift=1, mode_r=1: sreg <= {sreg[W-2:0], serial_in}.
  - Each shift increments bit_count.
  - shift=1 with bit_count==WORD_LENGTH-1: next state DONE and bit_count wraps to 0.
  - shift=0: all state holds, and the bit stays on data_out indefinitely.
  - load while in SHIFT is ignored; no restart occurs.
- DONE:
  - done=1 for exactly this one cycle; busy=0; data_out=0.
  - load=1 here is accepted as in IDLE, giving back-to-back words with no gap; otherwise next state is IDLE.
- data_out is forced to 0 in IDLE and DONE.
- data_q always reflects the shift register. After W shifts it holds the serial_in bits, which is used for chaining and for collecting multiplier results.
- clear=1 (any state):
  - Next state IDLE, sreg=0, bit_count=0.
  - No done pulse.
  - Overrides a simultaneous load.
- Reset asserted mid-word: immediate return to reset values; no done pulse.

Decomposition:
- Shared package piso_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - order constants LSB_FIRST=1'b0, MSB_FIRST=1'b1.
- One sub-module is natural: bit_counter. It is a CNT_W-bit up-counter with inc, sync clear and a terminal-count flag at WORD_LENGTH-1, with the same clk/reset ports.
- The FSM and the shift register stay in piso_serializer.

Test Plan:
1. Reset:
   - Drive reset=1 mid-simulation with random inputs -> all outputs 0 within the same time step.
   - After release, busy=0 and done=0.
2. LSB-first:
   - W=4: load 4'b1011 with msb_first=0, then shift=1 continuously -> data_out 1,1,0,1 on successive cycles.
   - bit_count 0,1,2,3; done=1 in the cycle after the 4th shift; busy then 0.
3. MSB-first and chaining:
   - Load 4'b1011 with msb_first=1 and serial_in=1 -> data_out 1,0,1,1.
   - data_q=4'b1111 at done.
4. Stalls and ignored load:
   - Shift pattern 1,0,0,1,1,1 -> data_out holds during the gaps; total 4 bits; done only after the 4th shift.
   - load=1 with data_in=4'b0000 while busy -> no effect on the sequence.
5. Back-to-back and abort:
   - load 4'b0110 in the DONE cycle -> SHIFT next cycle with data_out=0 (LSB of 0110); no idle gap.
   - clear after 2 shifts -> IDLE, bit_count=0, no done pulse.
6. Width generalisation:
   - WORD_LENGTH=8, load 8'hA5 with msb_first=0 -> data_out 1,0,1,0,0,1,0,1; done after 8 shifts.
   - bit_count wraps from 7 to 0.
